// File: rtl/jtframe_sdram_stats_pkg.sv
// Shared command encodings, readout map and counter arithmetic for the
// SDRAM command profiler.
package jtframe_sdram_stats_pkg;

    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_REF = 3'b001;

    localparam int IDX_REF    = 16;
    localparam int IDX_FRAMES = 17;
    localparam int IDX_ID     = 18;

    // Per-bank counter slot; also the low two bits of the readout index.
    typedef enum logic [1:0] {
        K_ACT  = 2'd0,
        K_RD   = 2'd1,
        K_WR   = 2'd2,
        K_SAME = 2'd3
    } cnt_kind_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic [15:0] max);
        return (val >= max) ? val : val + 16'd1;
    endfunction

    // A frame restarts the window; the event of that cycle belongs to the new one.
    function automatic logic [15:0] cnt_next(input logic [15:0] val, input logic ev,
                                             input logic frame, input logic [15:0] max);
        if (frame) return {15'd0, ev};
        return ev ? sat_inc(val, max) : val;
    endfunction

endpackage

// File: rtl/jtframe_sdram_stats_bank.sv
// One bank's live counters, frame snapshots and same-row tracker.
module jtframe_sdram_stats_bank
    import jtframe_sdram_stats_pkg::*;
#(
    parameter int CW   = 16,
    parameter int ROWW = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_act,
    input  logic                 cmd_rd,
    input  logic                 cmd_wr,
    input  logic                 frame,
    input  logic                 hold,
    input  logic [ROWW-1:0]      row,
    output logic [3:0][CW-1:0]   o_shadow
);

    localparam logic [15:0] MAX = 16'((1 << CW) - 1);

    logic [3:0][CW-1:0] r_live;
    logic [3:0][CW-1:0] r_shadow;
    logic [ROWW-1:0]    r_last_row;
    logic               r_row_vld;
    logic [3:0]         w_ev;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_ev         = '0;
        w_ev[K_ACT]  = cmd_act;
        w_ev[K_RD]   = cmd_rd;
        w_ev[K_WR]   = cmd_wr;
        w_ev[K_SAME] = cmd_act && r_row_vld && (row == r_last_row);
    end

    always_ff @(posedge clk) begin
        // NOTE: all profiling state is reset (not just control) so a reset discards the partial window.
        if (!rst) begin
            r_live     <= '0;
            r_shadow   <= '0;
            r_last_row <= '0;
            r_row_vld  <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                // NOTE: non-blocking assignment, so the shadow takes the pre-edge live value.
                r_live[k] <= CW'(cnt_next(16'(r_live[k]), w_ev[k], frame, MAX));
                if (frame && !hold) r_shadow[k] <= r_live[k];
            end
            if (cmd_act) begin
                r_last_row <= row;
                r_row_vld  <= 1'b1;
            end
        end
    end

    assign o_shadow = r_shadow;

endmodule

// File: rtl/jtframe_sdram_stats.sv
// Per-bank SDRAM command profiler: snoops command pins, snapshots counts on
// each LVBL falling edge and serves them byte-wise on st_addr/st_dout.
module jtframe_sdram_stats
    import jtframe_sdram_stats_pkg::*;
#(
    parameter int BANKS = 4,
    parameter int CW    = 16,
    parameter int ROWW  = 13
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sdram_ncs,
    input  logic            sdram_nras,
    input  logic            sdram_ncas,
    input  logic            sdram_nwe,
    input  logic [1:0]      sdram_ba,
    input  logic [ROWW-1:0] sdram_a,
    input  logic            LVBL,
    input  logic            hold,
    input  logic [7:0]      st_addr,
    output logic [7:0]      st_dout
);

    localparam logic [15:0] MAX     = 16'((1 << CW) - 1);
    localparam logic [15:0] ID_WORD = {8'd0, 4'(BANKS), 4'(CW) - 4'd1};

    logic [2:0]         w_cmd;
    logic               w_act;
    logic               w_rd;
    logic               w_wr;
    logic               w_ref;
    logic               w_frame;
    logic               r_lvbl_l;
    logic [CW-1:0]      r_ref;
    logic [CW-1:0]      r_ref_sh;
    logic [CW-1:0]      r_frames;
    logic [CW-1:0]      r_frames_sh;
    logic [3:0][CW-1:0] w_bank_sh [4];
    logic [6:0]         w_idx;
    logic [15:0]        w_word;

    assign w_cmd   = {sdram_nras, sdram_ncas, sdram_nwe};
    assign w_act   = !sdram_ncs && (w_cmd == CMD_ACT);
    assign w_rd    = !sdram_ncs && (w_cmd == CMD_RD);
    assign w_wr    = !sdram_ncs && (w_cmd == CMD_WR);
    assign w_ref   = !sdram_ncs && (w_cmd == CMD_REF);
    assign w_frame = !LVBL && r_lvbl_l;

    for (genvar b = 0; b < 4; b++) begin : g_bank
        if (b < BANKS) begin : g_on
            logic w_hit;
            assign w_hit = (sdram_ba == 2'(b));
            jtframe_sdram_stats_bank #(
                .CW   (CW),
                .ROWW (ROWW)
            ) u_bank (
                .clk      (clk),
                .rst      (rst),
                .cmd_act  (w_act && w_hit),
                .cmd_rd   (w_rd && w_hit),
                .cmd_wr   (w_wr && w_hit),
                .frame    (w_frame),
                .hold     (hold),
                .row      (sdram_a),
                .o_shadow (w_bank_sh[b])
            );
        end else begin : g_off
            assign w_bank_sh[b] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lvbl_l    <= 1'b0;
            r_ref       <= '0;
            r_ref_sh    <= '0;
            r_frames    <= '0;
            r_frames_sh <= '0;
            st_dout     <= '0;
        end else begin
            r_lvbl_l <= LVBL;
            r_ref    <= CW'(cnt_next(16'(r_ref), w_ref, w_frame, MAX));
            if (w_frame) begin
                // Frame count runs across windows and is published even while held.
                r_frames    <= CW'(sat_inc(16'(r_frames), MAX));
                r_frames_sh <= CW'(sat_inc(16'(r_frames), MAX));
                if (!hold) r_ref_sh <= r_ref;
            end
            st_dout <= st_addr[0] ? w_word[15:8] : w_word[7:0];
        end
    end

    assign w_idx = st_addr[7:1];

    always_comb begin
        w_word = '0;
        if (w_idx < 7'(IDX_REF))
            w_word = 16'(w_bank_sh[w_idx[3:2]][w_idx[1:0]]);
        else if (w_idx == 7'(IDX_REF))
            w_word = 16'(r_ref_sh);
        else if (w_idx == 7'(IDX_FRAMES))
            w_word = 16'(r_frames_sh);
        else if (w_idx == 7'(IDX_ID))
            w_word = ID_WORD;
    end

endmodule

// File: tb/tb_jtframe_sdram_stats.sv
// Scoreboard bench: three profiler configurations share one command stream
// and are compared against a window-level behavioural model.
module tb_jtframe_sdram_stats;

    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam int ND = 3;
    localparam int P_BANKS [ND] = '{4, 4, 2};
    localparam int P_CW    [ND] = '{16, 8, 16};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ncs = 1'b1;
    logic        nras = 1'b1;
    logic        ncas = 1'b1;
    logic        nwe = 1'b1;
    logic [1:0]  ba = '0;
    logic [12:0] a = '0;
    logic        lvbl = 1'b1;
    logic        hold = 1'b0;
    logic [7:0]  st_addr = '0;
    logic [7:0]  dout [ND];

    always #5 clk = ~clk;

    jtframe_sdram_stats #(.BANKS(4), .CW(16), .ROWW(13)) u_dut0 (
        .clk(clk), .rst(rst), .sdram_ncs(ncs), .sdram_nras(nras), .sdram_ncas(ncas),
        .sdram_nwe(nwe), .sdram_ba(ba), .sdram_a(a), .LVBL(lvbl), .hold(hold),
        .st_addr(st_addr), .st_dout(dout[0]));
    jtframe_sdram_stats #(.BANKS(4), .CW(8), .ROWW(13)) u_dut1 (
        .clk(clk), .rst(rst), .sdram_ncs(ncs), .sdram_nras(nras), .sdram_ncas(ncas),
        .sdram_nwe(nwe), .sdram_ba(ba), .sdram_a(a), .LVBL(lvbl), .hold(hold),
        .st_addr(st_addr), .st_dout(dout[1]));
    jtframe_sdram_stats #(.BANKS(2), .CW(16), .ROWW(13)) u_dut2 (
        .clk(clk), .rst(rst), .sdram_ncs(ncs), .sdram_nras(nras), .sdram_ncas(ncas),
        .sdram_nwe(nwe), .sdram_ba(ba), .sdram_a(a), .LVBL(lvbl), .hold(hold),
        .st_addr(st_addr), .st_dout(dout[2]));

    // Behavioural model: unbounded window counts, saturated only when read.
    int m_live [ND][4][4];
    int m_sh   [ND][4][4];
    int m_ref      [ND];
    int m_ref_sh   [ND];
    int m_frames   [ND];
    int m_frames_sh[ND];
    int m_last [ND][4];
    bit m_vld  [ND][4];
    bit m_lvbl_l;

    typedef struct {
        int         dut;
        int         idx;
        bit         hi;
        logic [7:0] exp;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    bit   req = 1'b0;
    bit   rsp_v = 1'b0;
    logic [2:0] cmds [6] = '{C_ACT, C_RD, C_WR, C_REF, C_NOP, C_PRE};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_step(input logic [2:0] cmd, input logic cs_n,
                                       input logic [1:0] bank, input logic [12:0] row,
                                       input logic lv);
        bit frame;
        int b;
        frame = !lv && m_lvbl_l;
        b = int'(bank);
        for (int d = 0; d < ND; d++) begin
            if (!rst) begin
                for (int i = 0; i < 4; i++) begin
                    for (int k = 0; k < 4; k++) begin
                        m_live[d][i][k] = 0;
                        m_sh[d][i][k] = 0;
                    end
                    m_vld[d][i] = 1'b0;
                    m_last[d][i] = 0;
                end
                m_ref[d] = 0; m_ref_sh[d] = 0; m_frames[d] = 0; m_frames_sh[d] = 0;
                continue;
            end
            if (frame) begin
                if (!hold) begin
                    for (int i = 0; i < 4; i++)
                        for (int k = 0; k < 4; k++) m_sh[d][i][k] = m_live[d][i][k];
                    m_ref_sh[d] = m_ref[d];
                end
                m_frames[d]++;
                m_frames_sh[d] = m_frames[d];
                for (int i = 0; i < 4; i++)
                    for (int k = 0; k < 4; k++) m_live[d][i][k] = 0;
                m_ref[d] = 0;
            end
            if (!cs_n) begin
                if (cmd == C_REF) m_ref[d]++;
                else if (b < P_BANKS[d]) begin
                    if (cmd == C_ACT) begin
                        m_live[d][b][0]++;
                        if (m_vld[d][b] && m_last[d][b] == int'(row)) m_live[d][b][3]++;
                        m_last[d][b] = int'(row);
                        m_vld[d][b] = 1'b1;
                    end else if (cmd == C_RD) m_live[d][b][1]++;
                    else if (cmd == C_WR) m_live[d][b][2]++;
                end
            end
        end
        m_lvbl_l = rst ? lv : 1'b0;
    endfunction

    function automatic logic [7:0] model_read(input int d, input int idx, input bit hi);
        int v;
        int mx;
        mx = (1 << P_CW[d]) - 1;
        v = 0;
        if (idx < 4 * P_BANKS[d]) v = m_sh[d][idx / 4][idx % 4];
        else if (idx == 16) v = m_ref_sh[d];
        else if (idx == 17) v = m_frames_sh[d];
        if (v > mx) v = mx;
        if (idx == 18) v = (P_BANKS[d] << 4) | ((P_CW[d] - 1) & 15);
        return hi ? 8'(v >> 8) : 8'(v);
    endfunction

    task automatic cyc(input logic [2:0] cmd, input logic cs_n, input logic [1:0] bank,
                       input logic [12:0] row, input logic lv);
        {nras, ncas, nwe} = cmd;
        ncs  = cs_n;
        ba   = bank;
        a    = row;
        lvbl = lv;
        model_step(cmd, cs_n, bank, row, lv);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(C_NOP, 1'b1, 2'd0, 13'd0, 1'b1);
    endtask

    task automatic frame_edge(input logic [2:0] cmd, input logic cs_n, input logic [1:0] bank);
        cyc(cmd, cs_n, bank, 13'd0, 1'b0);
        idle();
    endtask

    task automatic read_byte(input int idx, input bit hi);
        exp_t e;
        st_addr = {7'(idx), hi};
        for (int d = 0; d < ND; d++) begin
            e.dut = d; e.idx = idx; e.hi = hi; e.exp = model_read(d, idx, hi);
            sb_q.push_back(e);
        end
        req = 1'b1;
        idle();
        req = 1'b0;
    endtask

    task automatic read_word(input int idx);
        read_byte(idx, 1'b0);
        read_byte(idx, 1'b1);
    endtask

    task automatic read_all();
        for (int i = 0; i <= 18; i++) read_word(i);
        read_word(19);
        read_word(127);
    endtask

    always @(posedge clk) rsp_v <= req;

    always @(negedge clk) begin
        if (rsp_v) begin
            for (int i = 0; i < ND; i++) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: got 0 entries, expected 1");
                end else begin
                    mon_e = sb_q.pop_front();
                    check($sformatf("dut%0d idx%0d.%s", mon_e.dut, mon_e.idx, mon_e.hi ? "hi" : "lo"),
                          32'(dout[mon_e.dut]), 32'(mon_e.exp));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (3) idle();
        rst = 1'b1;
        idle();
        read_all();

        // Bank 2 counts with same-row re-activations
        cyc(C_ACT, 1'b0, 2'd2, 13'h10, 1'b1);
        cyc(C_ACT, 1'b0, 2'd2, 13'h10, 1'b1);
        cyc(C_ACT, 1'b0, 2'd2, 13'h20, 1'b1);
        cyc(C_ACT, 1'b0, 2'd2, 13'h20, 1'b1);
        cyc(C_ACT, 1'b0, 2'd2, 13'h20, 1'b1);
        repeat (7) cyc(C_RD, 1'b0, 2'd2, 13'h20, 1'b1);
        repeat (3) cyc(C_WR, 1'b0, 2'd2, 13'h20, 1'b1);
        frame_edge(C_NOP, 1'b1, 2'd0);
        for (int i = 8; i <= 11; i++) read_word(i);
        read_word(17);

        // Saturation and refresh
        repeat (300) cyc(C_RD, 1'b0, 2'd0, 13'd0, 1'b1);
        repeat (4) cyc(C_REF, 1'b0, 2'(3), 13'd0, 1'b1);
        frame_edge(C_NOP, 1'b1, 2'd0);
        read_word(1);
        read_word(16);
        read_word(17);

        // Command on the frame cycle belongs to the new window
        frame_edge(C_WR, 1'b0, 2'd1);
        read_word(6);
        frame_edge(C_NOP, 1'b1, 2'd0);
        read_word(6);

        // Hold freezes shadows but not frames
        hold = 1'b1;
        repeat (9) cyc(C_ACT, 1'b0, 2'd0, 13'($urandom_range(0, 3)), 1'b1);
        frame_edge(C_NOP, 1'b1, 2'd0);
        hold = 1'b0;
        read_word(0);
        read_word(17);
        repeat (2) cyc(C_ACT, 1'b0, 2'd0, 13'd5, 1'b1);
        frame_edge(C_NOP, 1'b1, 2'd0);
        read_word(0);

        // Mid-window reset discards partial counts
        repeat (6) cyc(C_RD, 1'b0, 2'd0, 13'd0, 1'b1);
        rst = 1'b0;
        idle();
        rst = 1'b1;
        cyc(C_RD, 1'b0, 2'd0, 13'd0, 1'b1);
        frame_edge(C_NOP, 1'b1, 2'd0);
        read_word(1);
        read_word(17);

        // Deselected commands and out-of-range banks
        cyc(C_ACT, 1'b1, 2'd0, 13'd1, 1'b1);
        cyc(C_RD,  1'b1, 2'd1, 13'd1, 1'b1);
        cyc(C_REF, 1'b1, 2'd0, 13'd1, 1'b1);
        cyc(C_ACT, 1'b0, 2'd3, 13'd1, 1'b1);
        cyc(C_ACT, 1'b0, 2'd3, 13'd1, 1'b1);
        cyc(C_RD,  1'b0, 2'd3, 13'd1, 1'b1);
        cyc(C_WR,  1'b0, 2'd2, 13'd1, 1'b1);
        cyc(C_REF, 1'b0, 2'd2, 13'd1, 1'b1);
        cyc(C_PRE, 1'b0, 2'd0, 13'd1, 1'b1);
        frame_edge(C_NOP, 1'b1, 2'd0);
        read_all();

        // Randomized traffic with random frames and hold
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 400; i++) begin
                hold = ($urandom_range(0, 3) == 0);
                cyc(cmds[$urandom_range(0, 5)], ($urandom_range(0, 7) == 0),
                    2'($urandom_range(0, 3)), 13'($urandom_range(0, 3)),
                    ($urandom_range(0, 15) != 0));
            end
            hold = 1'b0;
            idle();
            frame_edge(cmds[$urandom_range(0, 5)], 1'b0, 2'($urandom_range(0, 3)));
            read_all();
        end

        idle();
        idle();
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
